// File: rtl/letreiro_pkg.sv
// Shared definitions for the scrolling sign controller: FSM states,
// 3-bit letter codes, message length and the circular message table.
package letreiro_pkg;

  typedef enum logic [1:0] {
    PARADO  = 2'b00,
    ROLANDO = 2'b01,
    PAUSADO = 2'b10
  } estado_t;

  localparam logic [2:0] COD_U       = 3'b000;
  localparam logic [2:0] COD_F       = 3'b001;
  localparam logic [2:0] COD_E       = 3'b010;
  localparam logic [2:0] COD_R       = 3'b011;
  localparam logic [2:0] COD_S       = 3'b100;
  localparam logic [2:0] COD_A       = 3'b101;
  localparam logic [2:0] COD_APAGADO = 3'b111;

  localparam int unsigned MSG_LEN = 10;

  // Entry 0 sits in the low three bits.
  localparam logic [3*MSG_LEN-1:0] MENSAGEM = {
    COD_APAGADO, COD_APAGADO, COD_APAGADO, COD_APAGADO,
    COD_A, COD_S, COD_R, COD_E, COD_F, COD_U
  };

  // (pos + k) mod MSG_LEN, for pos already in 0..MSG_LEN-1 and k in 0..3.
  function automatic logic [3:0] indice_circular(input logic [3:0] pos,
                                                 input logic [1:0] k);
    logic [4:0] soma;
    soma = {1'b0, pos} + {3'b000, k};
    if (soma >= 5'(MSG_LEN)) begin
      soma = soma - 5'(MSG_LEN);
    end
    return soma[3:0];
  endfunction

  // Message lookup; out-of-range indices read as blank.
  function automatic logic [2:0] letra(input logic [3:0] idx);
    logic [2:0] cod;
    cod = COD_APAGADO;
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      if (idx == 4'(i)) begin
        cod = MENSAGEM[3*i +: 3];
      end
    end
    return cod;
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Scroll-step prescaler: counts 0..DIVISOR-1 while enabled and flags the
// terminal count as a tick; limpa restarts the count from zero.
module divisor_tick #(
  parameter int unsigned DIVISOR = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic habilita,
  input  logic limpa,
  output logic tick
);

  localparam int unsigned W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [W-1:0] ULTIMO = W'(DIVISOR - 1);

  logic [W-1:0] cont_q, cont_d;

  assign tick = habilita && (cont_q == ULTIMO);

  // Next count: clear has priority, otherwise count and wrap while enabled.
  always_comb begin
    cont_d = cont_q;
    if (limpa) begin
      cont_d = '0;
    end else if (habilita) begin
      if (cont_q == ULTIMO) begin
        cont_d = '0;
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

endmodule

// File: rtl/controle_letreiro.sv
// Scrolling sign controller: walks a 10-entry circular message across four
// 3-bit letter outputs, with start/stop/pause control and scroll direction.
module controle_letreiro
  import letreiro_pkg::*;
#(
  parameter int unsigned DIVISOR = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       pausar,
  input  logic       direcao,
  output logic [2:0] codigo0,
  output logic [2:0] codigo1,
  output logic [2:0] codigo2,
  output logic [2:0] codigo3,
  output logic [3:0] posicao,
  output logic       passo,
  output logic [1:0] estado
);

  estado_t    estado_q, estado_d;
  logic [3:0] pos_q, pos_d;
  logic       passo_q, passo_d;
  logic       habilita, limpa, tick;

  // Prescaler only runs in an undisturbed ROLANDO cycle, so a tick that
  // coincides with parar/iniciar/pausar is never produced; this also keeps
  // the tick independent of the FSM's own next-state logic.
  assign habilita = (estado_q == ROLANDO) && !parar && !iniciar && !pausar;
  assign limpa    = parar || iniciar;

  divisor_tick #(
    .DIVISOR (DIVISOR)
  ) u_divisor (
    .clock    (clock),
    .reset    (reset),
    .habilita (habilita),
    .limpa    (limpa),
    .tick     (tick)
  );

  // FSM and position update, priority parar > iniciar > pausar > tick.
  always_comb begin
    estado_d = estado_q;
    pos_d    = pos_q;
    passo_d  = 1'b0;
    if (parar) begin
      estado_d = PARADO;
      pos_d    = '0;
    end else if (iniciar) begin
      estado_d = ROLANDO;
      pos_d    = '0;
    end else begin
      unique case (estado_q)
        ROLANDO: begin
          if (pausar) begin
            estado_d = PAUSADO;
          end else if (tick) begin
            passo_d = 1'b1;
            if (direcao) begin
              pos_d = (pos_q == 4'd0) ? 4'(MSG_LEN - 1) : pos_q - 4'd1;
            end else begin
              pos_d = (pos_q == 4'(MSG_LEN - 1)) ? 4'd0 : pos_q + 4'd1;
            end
          end
        end
        PAUSADO: begin
          if (!pausar) begin
            estado_d = ROLANDO;
          end
        end
        default: begin
          estado_d = PARADO;
        end
      endcase
    end
  end

  // State, position and step-pulse registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= PARADO;
      pos_q    <= '0;
      passo_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pos_q    <= pos_d;
      passo_q  <= passo_d;
    end
  end

  // Letter outputs derived from registered state so they align with posicao.
  always_comb begin
    codigo0 = COD_APAGADO;
    codigo1 = COD_APAGADO;
    codigo2 = COD_APAGADO;
    codigo3 = COD_APAGADO;
    if (estado_q != PARADO) begin
      codigo0 = letra(indice_circular(pos_q, 2'd0));
      codigo1 = letra(indice_circular(pos_q, 2'd1));
      codigo2 = letra(indice_circular(pos_q, 2'd2));
      codigo3 = letra(indice_circular(pos_q, 2'd3));
    end
  end

  assign posicao = pos_q;
  assign passo   = passo_q;
  assign estado  = estado_q;

endmodule

// File: tb/tb_controle_letreiro.sv
// Self-checking bench for controle_letreiro with DIVISOR=4. Each cycle the
// expected {estado, posicao, passo, codigo0..3} is pushed to a scoreboard
// queue before the clock edge and popped/compared just after it.
module tb_controle_letreiro;

  logic       clock = 1'b0;
  logic       reset, iniciar, parar, pausar, direcao;
  logic [2:0] codigo0, codigo1, codigo2, codigo3;
  logic [3:0] posicao;
  logic       passo;
  logic [1:0] estado;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [18:0] exp_q[$];
  logic [18:0] got, want;

  localparam logic [1:0] S_PARADO  = 2'b00;
  localparam logic [1:0] S_ROLANDO = 2'b01;
  localparam logic [1:0] S_PAUSADO = 2'b10;

  controle_letreiro #(
    .DIVISOR (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .iniciar (iniciar),
    .parar   (parar),
    .pausar  (pausar),
    .direcao (direcao),
    .codigo0 (codigo0),
    .codigo1 (codigo1),
    .codigo2 (codigo2),
    .codigo3 (codigo3),
    .posicao (posicao),
    .passo   (passo),
    .estado  (estado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Expected output word built from the bench's own message table.
  function automatic logic [18:0] pack_exp(input logic [1:0] st,
                                           input int pos, input logic ps);
    logic [2:0] tab [10];
    logic [11:0] cods;
    tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
            3'b111, 3'b111, 3'b111, 3'b111};
    if (st == S_PARADO) cods = 12'hfff;
    else cods = {tab[pos % 10], tab[(pos + 1) % 10],
                 tab[(pos + 2) % 10], tab[(pos + 3) % 10]};
    return {st, 4'(pos), ps, cods};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic r, input logic i, input logic p,
                        input logic pa, input logic d);
    reset = r; iniciar = i; parar = p; pausar = pa; direcao = d;
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0);
    exp_q.push_back(pack_exp(S_PARADO, 0, 0));
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %h want %h", c, got, want);
      end
      exp_q.push_back(pack_exp(S_PARADO, 0, 0));
      step();
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_forward();
    set_in(0, 1, 0, 0, 0);
    exp_q.push_back(pack_exp(S_ROLANDO, 0, 0));
    step();
    iniciar = 1'b0;
    got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL fwd_start: got %h want %h", got, want);
    end
    for (int c = 1; c <= 40; c++) begin
      exp_q.push_back(pack_exp(S_ROLANDO, (c / 4) % 10, (c % 4) == 0));
      step();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL fwd[%0d]: got %h want %h", c, got, want);
      end
    end
  endtask

  // Continues from posicao=0 at a fresh prescaler count.
  task automatic test_reverse();
    int p;
    direcao = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      p = (c < 4) ? 0 : (c < 8) ? 9 : 8;
      exp_q.push_back(pack_exp(S_ROLANDO, p, (c % 4) == 0));
      step();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rev[%0d]: got %h want %h", c, got, want);
      end
    end
    direcao = 1'b0;
  endtask

  task automatic test_pause();
    logic [1:0] st;
    int         p;
    logic       ps;
    set_in(0, 1, 0, 0, 0);
    exp_q.push_back(pack_exp(S_ROLANDO, 0, 0));
    step();
    iniciar = 1'b0;
    got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pause_start: got %h want %h", got, want);
    end
    // c=1..4 first step, c=5..6 two cycles into the next step,
    // c=7..16 paused, c=17 resume edge, c=18 count, c=19 step completes.
    for (int c = 1; c <= 19; c++) begin
      pausar = (c >= 7 && c <= 16);
      st = (c >= 7 && c <= 16) ? S_PAUSADO : S_ROLANDO;
      p  = (c < 4) ? 0 : (c < 19) ? 1 : 2;
      ps = (c == 4) || (c == 19);
      exp_q.push_back(pack_exp(st, p, ps));
      step();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pause[%0d]: got %h want %h", c, got, want);
      end
    end
    pausar = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [1:0] st;
    int         p;
    // parar wins over iniciar while scrolling.
    set_in(0, 1, 1, 0, 0);
    exp_q.push_back(pack_exp(S_PARADO, 0, 0));
    step();
    set_in(0, 0, 0, 0, 0);
    got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL stop_vs_start: got %h want %h", got, want);
    end
    // Start, then pausar exactly on the tick cycle (c=4), release at c=5.
    iniciar = 1'b1;
    exp_q.push_back(pack_exp(S_ROLANDO, 0, 0));
    step();
    iniciar = 1'b0;
    void'(exp_q.pop_front());
    for (int c = 1; c <= 6; c++) begin
      pausar = (c == 4);
      st = (c == 4) ? S_PAUSADO : S_ROLANDO;
      p  = (c == 6) ? 1 : 0;
      exp_q.push_back(pack_exp(st, p, c == 6));
      step();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pause_vs_tick[%0d]: got %h want %h", c, got, want);
      end
    end
    pausar = 1'b0;
  endtask

  task automatic test_restart();
    set_in(0, 1, 0, 0, 0);
    exp_q.push_back(pack_exp(S_ROLANDO, 0, 0));
    step();
    iniciar = 1'b0;
    void'(exp_q.pop_front());
    // Reach posicao=5 and go two cycles into the next step.
    for (int c = 1; c <= 22; c++) begin
      exp_q.push_back(pack_exp(S_ROLANDO, c / 4, (c % 4) == 0));
      step();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL restart_run[%0d]: got %h want %h", c, got, want);
      end
    end
    // Restart: back to 0 without passo, prescaler restarts from zero.
    iniciar = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      exp_q.push_back(pack_exp(S_ROLANDO, (c == 4) ? 1 : 0, c == 4));
      step();
      iniciar = 1'b0;
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL restart[%0d]: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_stop_and_reset_mid_scroll();
    // Pause, then parar from PAUSADO.
    pausar = 1'b1;
    exp_q.push_back(pack_exp(S_PAUSADO, 1, 0));
    step();
    parar = 1'b1;
    exp_q.push_back(pack_exp(S_PARADO, 0, 0));
    step();
    set_in(0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      want = exp_q.pop_front();
      got  = (c == 0) ? want : {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      if (c == 1) begin
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL stop_from_pause: got %h want %h", got, want);
        end
      end
    end
    // Reset on the pending-tick cycle: the tick is discarded.
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    exp_q.push_back(pack_exp(S_PARADO, 0, 0));
    step();
    reset = 1'b0;
    exp_q.push_back(pack_exp(S_PARADO, 0, 0));
    for (int c = 0; c < 2; c++) begin
      want = exp_q.pop_front();
      got  = {estado, posicao, passo, codigo0, codigo1, codigo2, codigo3};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h want %h", c, got, want);
      end
      step();
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0);
    step();
    test_reset();
    test_forward();
    test_reverse();
    test_pause();
    test_simultaneous();
    test_restart();
    test_stop_and_reset_mid_scroll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_letreiro.md
CONTROLE_LETREIRO -- requirements
Module: controle_letreiro

Interface
REQ-001 SHALL have parameter DIVISOR, default 50000000, meaning clock cycles per scroll step (1 Hz at 50 MHz); legal range 2 or greater.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-004 SHALL have port iniciar  input  1  start or restart scrolling (level sampled each cycle).
REQ-005 SHALL have port parar  input  1  stop and blank the displays.
REQ-006 SHALL have port pausar  input  1  level; freeze scrolling while high.
REQ-007 SHALL have port direcao  input  1  0 = position increments, 1 = position decrements.
REQ-008 SHALL have ports codigo0, codigo1, codigo2, codigo3  output  3 each  letter codes, one per 7-segment decoder; codigo0 drives the leftmost digit.
REQ-009 SHALL have port posicao  output  4  current message index, 0 to 9.
REQ-010 SHALL have port passo  output  1  one-cycle pulse on the cycle after posicao changes by a scroll step.
REQ-011 SHALL have port estado  output  2  current state: 00 PARADO, 01 ROLANDO, 10 PAUSADO.

Function
REQ-012 SHALL encode the letter codes as U=000, F=001, E=010, R=011, S=100, A=101, blank=111; code 110 is never driven.
REQ-013 SHALL hold a circular message of 10 entries: U F E R S A blank blank blank blank, indices 0 to 9.
REQ-014 SHALL drive codigoK = message[(posicao+K) mod 10] in ROLANDO and PAUSADO, and 111 on all four outputs in PARADO.
REQ-015 SHALL derive the codigo outputs combinationally from the registered state and posicao, so they are valid in the same cycle as posicao.
REQ-016 SHALL run a prescaler counting 0 to DIVISOR-1 only in ROLANDO; reaching DIVISOR-1 is a tick, and the counter wraps to 0.
REQ-017 SHALL, on a tick in ROLANDO, advance posicao: 9 wraps to 0 when direcao=0, and 0 wraps to 9 when direcao=1.
REQ-018 SHALL implement the PARADO to ROLANDO transition when iniciar=1, loading posicao=0 and prescaler=0.
REQ-019 SHALL implement the ROLANDO to PAUSADO transition when pausar=1; the prescaler and posicao hold.
REQ-020 SHALL implement the PAUSADO to ROLANDO transition when pausar=0; the prescaler resumes from its held value.
REQ-021 SHALL implement the transition from any state to PARADO when parar=1, clearing posicao and the prescaler.
REQ-022 SHALL, when iniciar=1 in ROLANDO or PAUSADO, restart the sequence: state becomes ROLANDO, posicao=0, prescaler=0.
REQ-023 SHALL apply this priority when inputs coincide: reset > parar > iniciar > pausar > tick; a tick in the same cycle as pausar=1 does not advance.
REQ-024 SHALL sample direcao only on the tick cycle; a change between ticks takes effect on the next step.
REQ-025 SHALL assert passo for exactly the one cycle following each advancing tick, and never on restart or stop.

Reset
REQ-026 SHALL, on reset, force state PARADO, posicao=0, prescaler=0, passo=0, all codigo outputs=111, and estado=00.
REQ-027 SHALL let reset asserted mid-scroll take effect at the next edge, discarding any pending tick.

Structure
REQ-028 SHALL take from shared package letreiro_pkg the state enumeration, the letter-code constants (COD_U through COD_A and COD_APAGADO), MSG_LEN=10, and the message table.
REQ-029 SHALL place the prescaler in a single sub-module divisor_tick (inputs clock, reset, habilita, limpa; output tick).
REQ-030 SHALL require that each codigo output be directly compatible with the existing 3-bit letter decoder input; no decoding is done in this block.

Verification
REQ-031 SHALL cover the reset scenario with DIVISOR=4: assert reset, then release -> estado=00, all codigo outputs=111, posicao=0, passo=0.
REQ-032 SHALL cover forward scrolling: pulse iniciar, direcao=0 -> codigo0..3 = 000,001,010,011; after 4 cycles posicao=1 with codes 001,010,011,100 and passo high for one cycle; after 40 cycles posicao wraps back to 0.
REQ-033 SHALL cover reverse scrolling: direcao=1 from posicao=0 -> next tick gives posicao=9 with codes 111,000,001,010.
REQ-034 SHALL cover pause and resume: raise pausar 2 cycles into a step for 10 cycles -> posicao is unchanged throughout and no passo; after release the step completes 2 cycles later.
REQ-035 SHALL cover simultaneous inputs: parar and iniciar high in the same cycle during ROLANDO -> PARADO with all codes 111; pausar and a tick in the same cycle -> PAUSADO with posicao unchanged.
REQ-036 SHALL cover restart mid-scroll: iniciar at posicao=5 -> posicao=0 on the next cycle, prescaler restarts, and no passo pulse.
